// File: rtl/rgmii_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rgmii_tx_framer                                                 |
// | Purpose  : RGMII transmit byte framer: preamble/SFD, pad, FCS, IFG, and    |
// |            rise/fall nibble split for per-lane ODDR primitives.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rgmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12,
    parameter bit APPEND_FCS   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] txd_rise,
    output logic [3:0] txd_fall,
    output logic       txctl_rise,
    output logic       txctl_fall,
    output logic       busy,
    output logic       underrun
);

    localparam int c_cnt_w = $clog2(MIN_FRAME + 1);
    localparam int c_pre_w = (PREAMBLE_LEN < 2) ? 1 : $clog2(PREAMBLE_LEN + 1);
    localparam int c_ifg_w = (IFG_BYTES < 2) ? 1 : $clog2(IFG_BYTES + 1);
    localparam int c_ifg_load_i = (IFG_BYTES > 0) ? IFG_BYTES - 1 : 0;

    localparam logic [c_cnt_w-1:0] c_min_frame = c_cnt_w'(MIN_FRAME);
    localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'((PREAMBLE_LEN > 1) ? PREAMBLE_LEN - 1 : 1);
    localparam logic [c_ifg_w-1:0] c_ifg_reset = c_ifg_w'(IFG_BYTES);
    localparam logic [c_ifg_w-1:0] c_ifg_load  = c_ifg_w'(c_ifg_load_i);
    localparam logic [31:0]        c_poly      = 32'hEDB88320;
    localparam logic [7:0]         c_pre_byte  = 8'h55;
    localparam logic [7:0]         c_sfd_byte  = 8'hD5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_SFD   = 4'd2,
        ST_DATA  = 4'd3,
        ST_PAD   = 4'd4,
        ST_FCS   = 4'd5,
        ST_ERR   = 4'd6,
        ST_DRAIN = 4'd7,
        ST_IFG   = 4'd8
    } state_t;

    state_t             r_state;
    logic [31:0]        r_crc;
    logic [c_cnt_w-1:0] r_byte_cnt;
    logic [c_pre_w-1:0] r_pre_cnt;
    logic [c_ifg_w-1:0] r_ifg_cnt;
    logic [1:0]         r_fcs_idx;
    logic [7:0]         r_txd;
    logic               r_ctl_rise;
    logic               r_ctl_fall;
    logic               r_ready;
    logic               r_busy;
    logic               r_underrun;

    logic [31:0]        w_fcs;
    logic [7:0]         w_fcs_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ c_poly) : (c >> 1);
        return c;
    endfunction

    assign w_fcs      = ~r_crc;
    assign w_fcs_byte = w_fcs[{r_fcs_idx, 3'b000} +: 8];

    // The state names the action taken at the coming edge; every output is
    // loaded at that edge, so s_ready rises while SFD is on the wire and the
    // first data byte follows SFD without a gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_crc      <= '1;
            r_byte_cnt <= '0;
            r_pre_cnt  <= '0;
            r_ifg_cnt  <= c_ifg_reset;
            r_fcs_idx  <= '0;
            r_txd      <= '0;
            r_ctl_rise <= 1'b0;
            r_ctl_fall <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_txd      <= '0;
            r_ctl_rise <= 1'b0;
            r_ctl_fall <= 1'b0;
            r_underrun <= 1'b0;
            r_busy     <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (r_ifg_cnt != '0) begin
                        r_ifg_cnt <= r_ifg_cnt - 1'b1;
                        r_busy    <= (r_ifg_cnt != c_ifg_w'(1));
                    end else if (s_valid) begin
                        r_busy     <= 1'b1;
                        r_txd      <= c_pre_byte;
                        r_ctl_rise <= 1'b1;
                        r_ctl_fall <= 1'b1;
                        r_pre_cnt  <= c_pre_w'(1);
                        r_state    <= (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;
                    end
                end
                ST_PRE: begin
                    r_txd      <= c_pre_byte;
                    r_ctl_rise <= 1'b1;
                    r_ctl_fall <= 1'b1;
                    r_pre_cnt  <= r_pre_cnt + 1'b1;
                    if (r_pre_cnt == c_pre_last)
                        r_state <= ST_SFD;
                end
                ST_SFD: begin
                    r_txd      <= c_sfd_byte;
                    r_ctl_rise <= 1'b1;
                    r_ctl_fall <= 1'b1;
                    r_crc      <= '1;
                    r_byte_cnt <= '0;
                    r_ready    <= 1'b1;
                    r_state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (s_valid) begin
                        r_txd      <= s_data;
                        r_ctl_rise <= 1'b1;
                        r_ctl_fall <= 1'b1;
                        r_crc      <= crc32_byte(r_crc, s_data);
                        if (r_byte_cnt != c_min_frame)
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (s_last) begin
                            r_ready <= 1'b0;
                            if (APPEND_FCS && (int'(r_byte_cnt) + 1 < MIN_FRAME)) begin
                                r_state <= ST_PAD;
                            end else if (APPEND_FCS) begin
                                r_fcs_idx <= '0;
                                r_state   <= ST_FCS;
                            end else begin
                                r_ifg_cnt <= c_ifg_load;
                                r_state   <= ST_IFG;
                            end
                        end
                    end else begin
                        // Underrun: one TX_ER symbol poisons the frame at the PHY
                        r_ctl_rise <= 1'b1;
                        r_ctl_fall <= 1'b0;
                        r_underrun <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= ST_ERR;
                    end
                end
                ST_PAD: begin
                    r_ctl_rise <= 1'b1;
                    r_ctl_fall <= 1'b1;
                    r_crc      <= crc32_byte(r_crc, 8'h00);
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    if (int'(r_byte_cnt) + 1 >= MIN_FRAME) begin
                        r_fcs_idx <= '0;
                        r_state   <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    r_txd      <= w_fcs_byte;
                    r_ctl_rise <= 1'b1;
                    r_ctl_fall <= 1'b1;
                    r_fcs_idx  <= r_fcs_idx + 1'b1;
                    if (r_fcs_idx == 2'd3) begin
                        r_ifg_cnt <= c_ifg_load;
                        r_state   <= ST_IFG;
                    end
                end
                ST_ERR: begin
                    // s_last can never have been accepted before an underrun
                    r_ready <= 1'b1;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (s_valid && s_last) begin
                        r_ready   <= 1'b0;
                        r_ifg_cnt <= c_ifg_load;
                        r_state   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (r_ifg_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt - 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = r_ready;
    assign txd_rise   = r_txd[3:0];
    assign txd_fall   = r_txd[7:4];
    assign txctl_rise = r_ctl_rise;
    assign txctl_fall = r_ctl_fall;
    assign busy       = r_busy;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_framer.sv
`default_nettype none
// Directed bench for rgmii_tx_framer: one FCS-enabled instance and one
// APPEND_FCS=0 instance, selected through a shared stimulus/observation mux.
module tb_rgmii_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, rst1_n, s_valid, s_last, sel;
    logic [7:0] s_data;

    logic       rdy0, rdy1, cr0, cr1, cf0, cf1, bz0, bz1, ur0, ur1;
    logic [3:0] tr0, tr1, tf0, tf1;

    logic       m_ready, m_ctl_rise, m_ctl_fall, m_busy, m_underrun;
    logic [3:0] m_txd_rise, m_txd_fall;

    rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12), .APPEND_FCS(1'b1)) u_dut (
        .clk(clk), .rst_n(rst0_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(rdy0), .txd_rise(tr0), .txd_fall(tf0), .txctl_rise(cr0), .txctl_fall(cf0),
        .busy(bz0), .underrun(ur0));

    rgmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12), .APPEND_FCS(1'b0)) u_dut_nofcs (
        .clk(clk), .rst_n(rst1_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(rdy1), .txd_rise(tr1), .txd_fall(tf1), .txctl_rise(cr1), .txctl_fall(cf1),
        .busy(bz1), .underrun(ur1));

    assign m_ready    = sel ? rdy1 : rdy0;
    assign m_txd_rise = sel ? tr1  : tr0;
    assign m_txd_fall = sel ? tf1  : tf0;
    assign m_ctl_rise = sel ? cr1  : cr0;
    assign m_ctl_fall = sel ? cf1  : cf0;
    assign m_busy     = sel ? bz1  : bz0;
    assign m_underrun = sel ? ur1  : ur0;

    int n_checks = 0;
    int n_pass   = 0;
    int sent, drained, idle_run, gap, err_cnt, ur_cnt, busy_lo, en_total, snap;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       rdy_q[$];

    always @(negedge clk) if (m_ctl_rise) en_total++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic send(input int len, input int gap_at, input int stop_at);
        int i, cyc;
        bit gapped;
        i = 0; cyc = 0; gapped = 1'b0; drained = 0;
        while (i < len && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (i == stop_at) begin
                rst0_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
                break;
            end
            if (i == gap_at && !gapped && m_ready) begin
                s_valid = 1'b0; s_last = 1'b0; gapped = 1'b1;
            end else begin
                s_valid = 1'b1; s_data = 8'(i); s_last = (i == len - 1);
                if (m_ready) begin
                    if (gapped) drained++;
                    i++;
                end
            end
        end
        sent = i;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic collect();
        int t;
        rx_q.delete(); rdy_q.delete();
        err_cnt = 0; ur_cnt = 0; busy_lo = 0; t = 0;
        @(negedge clk);
        while (!m_ctl_rise && t < 3000) begin
            idle_run++; t++;
            @(negedge clk);
        end
        gap = idle_run;
        t = 0;
        while (m_ctl_rise && t < 3000) begin
            rx_q.push_back({m_txd_fall, m_txd_rise});
            rdy_q.push_back(m_ready);
            if (!m_ctl_fall) err_cnt++;
            if (m_underrun) ur_cnt++;
            if (!m_busy) busy_lo++;
            t++;
            @(negedge clk);
        end
        idle_run = 1;
    endtask

    task automatic build_exp(input int len, input bit fcs);
        logic [31:0] c;
        int n;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = '1; n = 0;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(8'(k)); c = crc_byte(c, 8'(k)); n++;
        end
        if (fcs) begin
            for (; n < 60; n++) begin
                exp_q.push_back(8'h00); c = crc_byte(c, 8'h00);
            end
            c = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        end
    endtask

    task automatic cmp_frame(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_tx_en_cycles"}, rx_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) bad++;
        chk({tag, "_bad_bytes"}, bad, 0);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (m_busy && t < 500) begin
            t++;
            @(negedge clk);
        end
        chk(tag, m_busy, 0);
    endtask

    initial begin
        int ones;
        logic [31:0] c;
        string s;
        sel = 1'b0; rst0_n = 1'b0; rst1_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        idle_run = 0; en_total = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({m_txd_rise, m_txd_fall, m_ctl_rise, m_ctl_fall, m_busy, m_underrun, m_ready}), 0);

        s = "123456789"; c = '1;
        for (int k = 0; k < 9; k++) c = crc_byte(c, s[k]);
        chk("crc_model_123456789", ~c, 32'hCBF43926);

        // T1: 60-byte frame, no pad
        rst0_n = 1'b1;
        build_exp(60, 1'b1);
        fork send(60, -1, -1); collect(); join
        cmp_frame("t1");
        chk("t1_sent", sent, 60);
        ones = 0;
        foreach (rdy_q[k]) if (rdy_q[k]) ones++;
        chk("t1_ready_cycles", ones, 60);
        chk("t1_busy_low_in_frame", busy_lo, 0);

        // T2: 10-byte frame padded to 60
        build_exp(10, 1'b1);
        fork send(10, -1, -1); collect(); join
        cmp_frame("t2");
        ones = 0;
        for (int k = 18; k < rdy_q.size(); k++) if (rdy_q[k]) ones++;
        chk("t2_ready_during_pad", ones, 0);

        // T3: back-to-back 64-byte frames
        build_exp(64, 1'b1);
        fork
            begin send(64, -1, -1); send(64, -1, -1); end
            begin collect(); cmp_frame("t3a"); collect(); end
        join
        cmp_frame("t3b");
        chk("t3_ifg_idle_cycles", gap, 12);

        // T4: underrun at byte 20 of 100
        wait_idle("t3_busy_clear");
        build_exp(20, 1'b0);
        exp_q.push_back(8'h00);
        snap = en_total;
        fork send(100, 20, -1); collect(); join
        cmp_frame("t4");
        chk("t4_err_cycles", err_cnt, 1);
        chk("t4_underrun_pulses", ur_cnt, 1);
        chk("t4_drained", drained, 80);
        chk("t4_sent", sent, 100);
        wait_idle("t4_busy_clear");
        chk("t4_total_tx_en", en_total - snap, 29);

        // T5: reset at byte 30, then IFG after release
        send(100, -1, 30);
        chk("t5_outputs_after_reset", 32'({m_txd_rise, m_txd_fall, m_ctl_rise, m_ctl_fall, m_busy, m_underrun, m_ready}), 0);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1; s_valid = 1'b1; s_data = '0; s_last = 1'b0;
        idle_run = 0;
        build_exp(10, 1'b1);
        fork send(10, -1, -1); collect(); join
        chk("t5_idle_after_release", gap, 12);
        cmp_frame("t5");

        // T6: no FCS, no padding
        wait_idle("t5_busy_clear");
        rst0_n = 1'b0; rst1_n = 1'b1; sel = 1'b1;
        build_exp(10, 1'b0);
        fork send(10, -1, -1); collect(); join
        cmp_frame("t6");
        chk("t6_err_cycles", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
